// File: rtl/mem_refill_responder_if.sv
// Cache-side bus of the refill responder: the refill request, the write-through
// port and the beat stream returned to the cache.
interface mem_refill_responder_if;
  logic        MRd;
  logic [31:0] RAMAddr;
  logic        CMWr;
  logic [31:0] MDataOut;
  logic [31:0] WrAddrIn;
  logic [31:0] MDataIn;
  logic        WrStb;
  logic        Busy;
  logic        WrOvf;

  // The cache drives requests and write-throughs and receives the beats.
  modport master (
    output MRd, RAMAddr, CMWr, MDataOut,
    input  WrAddrIn, MDataIn, WrStb, Busy, WrOvf
  );

  modport slave (
    input  MRd, RAMAddr, CMWr, MDataOut,
    output WrAddrIn, MDataIn, WrStb, Busy, WrOvf
  );
endinterface

// File: rtl/mem_refill_responder.sv
// Backing-store model answering cache line refills with a 4-beat burst after a
// fixed latency, plus a write-through path with a single-entry write buffer.
module mem_refill_responder #(
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 3
) (
  input  logic                   CLK,
  input  logic                   CLR,
  mem_refill_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LAT, BURST, DONE} state_t;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic                mrd_q, mrd_d;
  logic                arm_q, arm_d;
  logic [27:0]         base_q, base_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic [1:0]          beat_q, beat_d;
  logic                wrstb_q, wrstb_d;
  logic [31:0]         wraddr_q, wraddr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                wb_v_q, wb_v_d;
  logic [MEM_AW-1:0]   wb_a_q, wb_a_d;
  logic [31:0]         wb_d_q, wb_d_d;
  logic                ovf_q, ovf_d;

  logic                mem_we;
  logic [MEM_AW-1:0]   mem_wa;
  logic [31:0]         mem_wd;
  logic [31:0]         mem_q [0:(1<<MEM_AW)-1];

  logic                req_fall;
  logic [31:0]         beat_addr;
  logic [MEM_AW-1:0]   wr_idx;
  logic                unused_addr_lsbs;

  // arm_q stays low after reset until MRd is seen high, so a request still
  // held low across reset cannot masquerade as a fresh falling edge.
  assign req_fall         = ~bus.MRd & mrd_q & arm_q;
  assign beat_addr        = {base_q, beat_q, 2'b00};
  assign wr_idx           = bus.RAMAddr[MEM_AW+1:2];
  assign unused_addr_lsbs = &{1'b0, bus.RAMAddr[1:0]};

  always_comb begin
    state_d   = state_q;
    mrd_d     = bus.MRd;
    arm_d     = arm_q | bus.MRd;
    base_d    = base_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    wrstb_d   = 1'b0;
    wraddr_d  = wraddr_q;
    rdata_d   = rdata_q;
    wb_v_d    = wb_v_q;
    wb_a_d    = wb_a_q;
    wb_d_d    = wb_d_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_wa    = wb_a_q;
    mem_wd    = wb_d_q;

    case (state_q)
      IDLE: begin
        if (req_fall) begin
          state_d   = LAT;
          base_d    = bus.RAMAddr[31:4];
          lat_cnt_d = 4'd0;
        end
      end
      LAT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = BURST;
          beat_d  = 2'd0;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      BURST: begin
        wrstb_d  = 1'b1;
        wraddr_d = beat_addr;
        rdata_d  = mem_q[beat_addr[MEM_AW+1:2]];
        beat_d   = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (bus.MRd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The store is never written during BURST/DONE, so every beat read sees
    // all commits without needing a bypass path.
    if (state_q == IDLE || state_q == LAT) begin
      if (wb_v_q) begin
        mem_we = 1'b1;
        wb_v_d = bus.CMWr;
        if (bus.CMWr) begin
          wb_a_d = wr_idx;
          wb_d_d = bus.MDataOut;
        end
      end else if (bus.CMWr) begin
        mem_we = 1'b1;
        mem_wa = wr_idx;
        mem_wd = bus.MDataOut;
      end
    end else if (bus.CMWr) begin
      if (!wb_v_q) begin
        wb_v_d = 1'b1;
        wb_a_d = wr_idx;
        wb_d_d = bus.MDataOut;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= IDLE;
      mrd_q     <= 1'b1;
      arm_q     <= 1'b0;
      lat_cnt_q <= 4'd0;
      beat_q    <= 2'd0;
      wrstb_q   <= 1'b0;
      wraddr_q  <= 32'd0;
      rdata_q   <= 32'd0;
      wb_v_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mrd_q     <= mrd_d;
      arm_q     <= arm_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
      wrstb_q   <= wrstb_d;
      wraddr_q  <= wraddr_d;
      rdata_q   <= rdata_d;
      wb_v_q    <= wb_v_d;
      ovf_q     <= ovf_d;
    end
  end

  // Payload registers are qualified by state/valid flags and need no reset.
  always_ff @(posedge CLK) begin
    base_q <= base_d;
    wb_a_q <= wb_a_d;
    wb_d_q <= wb_d_d;
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign bus.WrStb    = wrstb_q;
  assign bus.WrAddrIn = wraddr_q;
  assign bus.MDataIn  = rdata_q;
  assign bus.Busy     = (state_q != IDLE);
  assign bus.WrOvf    = ovf_q;

endmodule

// File: doc/mem_refill_responder.md
MEM_REFILL_RESPONDER -- requirements
Module: mem_refill_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, backing-store word-address width (2^MEM_AW 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 3, number of wait cycles before the first refill beat (legal 1..15).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 CLR  in  1  asynchronous, active-low reset.
REQ-005 MRd  in  1  refill request from cache, active-low level.
REQ-006 RAMAddr  in  32  miss address; line base = {RAMAddr[31:4],4'b0000}.
REQ-007 CMWr  in  1  write-through strobe; each cycle high is one word write.
REQ-008 MDataOut  in  32  write-through data, stored at RAMAddr.
REQ-009 WrAddrIn  out  32  refill beat byte address.
REQ-010 MDataIn  out  32  refill beat data.
REQ-011 WrStb  out  1  high for exactly one cycle per valid beat.
REQ-012 Busy  out  1  high in any state other than IDLE.
REQ-013 WrOvf  out  1  sticky: a write-through was dropped.

Function
REQ-014 Backing store SHALL be indexed by address[MEM_AW+1:2]; higher bits ignored (aliasing); bits [1:0] ignored.
REQ-015 States SHALL be IDLE, LAT, BURST, DONE.
REQ-016 IDLE->LAT when MRd sampled 0 and previous-cycle sample was 1 (falling edge); line base latched that edge.
REQ-017 LAT SHALL last exactly LATENCY cycles, then go to BURST.
REQ-018 BURST SHALL issue 4 beats on consecutive cycles at offsets 0x0, 0x4, 0x8, 0xC, WrStb high each beat, WrAddrIn = base+offset, MDataIn = store word at that address.
REQ-019 First WrStb SHALL be registered high LATENCY+1 edges after the request-sampling edge.
REQ-020 After beat 0xC, state SHALL be DONE; DONE->IDLE when MRd sampled 1; MRd low held in IDLE (no new falling edge) starts nothing.
REQ-021 WrAddrIn and MDataIn SHALL hold last beat values when WrStb is low.
REQ-022 Single-entry write buffer (addr, data, valid).
REQ-023 IDLE or LAT, buffer empty, CMWr=1: word committed to store that edge.
REQ-024 IDLE or LAT, buffer valid: buffer committed that edge; concurrent CMWr loads into buffer.
REQ-025 BURST or DONE, CMWr=1: loaded into buffer if empty, else dropped and WrOvf set.
REQ-026 Each beat SHALL return store contents including all writes committed on or before its read edge.
REQ-027 Write committed and request detected same edge in IDLE: refill SHALL return the new data.

Reset
REQ-028 CLR=0 SHALL immediately force IDLE, WrStb=0, Busy=0, WrOvf=0, WrAddrIn=0, MDataIn=0, buffer invalid, MRd history=1.
REQ-029 Reset mid-refill SHALL abort with no further beats; buffered write discarded; store contents unaffected by reset.
REQ-030 After release, a request still held low SHALL NOT start a refill until MRd returns 1 and falls again.

Verification
REQ-031 Store words 0x100..0x103 = A0,A1,A2,A3; LATENCY=3; MRd falls with RAMAddr=0x0000040C -> WrStb on edges 4..7 after request, WrAddrIn 0x400,0x404,0x408,0x40C, data A0..A3, then Busy until MRd=1.
REQ-032 CMWr with RAMAddr=0x408, MDataOut=0xDEADBEEF same edge as request for line 0x400 -> third beat returns 0xDEADBEEF.
REQ-033 Two CMWr during BURST -> first buffered and committed on first IDLE edge (readback by later refill), second dropped, WrOvf=1 until CLR.
REQ-034 CLR pulsed low after second beat -> outputs zero instantly, no further WrStb, MRd held low afterward produces no refill.
REQ-035 MEM_AW=10, request at 0x00001000 -> beats return words of line 0x000 (aliasing).
